// File: rtl/rgby_pkg.sv
// Shared RGBY colour codes, selector state encoding and default row geometry
// used by the nib selector and the motion controller.
package rgby_pkg;

  localparam logic [1:0] RGBY_R = 2'd0;
  localparam logic [1:0] RGBY_G = 2'd1;
  localparam logic [1:0] RGBY_B = 2'd2;
  localparam logic [1:0] RGBY_Y = 2'd3;

  localparam int unsigned ROW_NIB_COUNT = 10;

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_SETTLE,
    SEL_WAIT,
    SEL_NEXT,
    SEL_OUTPUT
  } sel_state_t;

endpackage

// File: rtl/cycle_timer.sv
// Clearable up-counter that flags the cycle on which it reaches LIMIT-1.
module cycle_timer #(
  parameter int unsigned LIMIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset)     count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  // done looks at the incremented value, so the owner leaves its state on the
  // same edge the counter reaches LIMIT-1; LIMIT=1 is done on the first cycle.
  assign done = en && ((32'(count) + 32'd1) >= (LIMIT - 32'd1));

endmodule

// File: rtl/nib_selector.sv
// Row-scan stage: steps the sensor mux over every nib, samples each colour,
// packs the row and hands it off over valid/ready before pulsing complete.
module nib_selector
  import rgby_pkg::*;
#(
  parameter int unsigned NIB_COUNT      = ROW_NIB_COUNT,
  parameter int unsigned SEL_W          = 4,
  parameter int unsigned SETTLE_CYCLES  = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startSelector,
  output logic [SEL_W-1:0]       sensorSelect,
  output logic                   sampleReq,
  input  logic                   sampleValid,
  input  logic [1:0]             colorCode,
  output logic [2*NIB_COUNT-1:0] rowData,
  output logic [NIB_COUNT-1:0]   errorMask,
  output logic                   rowValid,
  input  logic                   rowReady,
  output logic                   selectorComplete,
  output logic                   busy
);

  localparam int unsigned IDX_W = (NIB_COUNT > 1) ? $clog2(NIB_COUNT) : 1;
  localparam int unsigned ROW_W = 2 * NIB_COUNT;

  sel_state_t       state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [SEL_W-1:0] sel_d;
  logic             req_d;
  logic [ROW_W-1:0] row_d;
  logic [NIB_COUNT-1:0] err_d;
  logic             valid_d;
  logic             done_d;

  logic settle_clear, settle_en, settle_done;
  logic tmo_clear, tmo_en, tmo_done;

  cycle_timer #(.LIMIT(SETTLE_CYCLES)) u_settle (
    .clk   (clk),
    .reset (reset),
    .clear (settle_clear),
    .en    (settle_en),
    .done  (settle_done)
  );

  cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (tmo_clear),
    .en    (tmo_en),
    .done  (tmo_done)
  );

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    sel_d        = sensorSelect;
    req_d        = 1'b0;
    row_d        = rowData;
    err_d        = errorMask;
    valid_d      = rowValid;
    done_d       = 1'b0;
    settle_clear = 1'b0;
    tmo_clear    = 1'b0;
    settle_en    = (state == SEL_SETTLE);
    tmo_en       = (state == SEL_WAIT);

    unique case (state)
      SEL_IDLE: begin
        if (startSelector) begin
          idx_d        = '0;
          sel_d        = '0;
          row_d        = '0;
          err_d        = '0;
          settle_clear = 1'b1;
          state_d      = SEL_SETTLE;
        end
      end
      SEL_SETTLE: begin
        if (settle_done) begin
          req_d     = 1'b1;
          tmo_clear = 1'b1;
          state_d   = SEL_WAIT;
        end
      end
      SEL_WAIT: begin
        // A sample on the timeout cycle still wins over the error.
        if (sampleValid) begin
          row_d   = (rowData & ~(ROW_W'(2'b11) << {idx, 1'b0}))
                  | (ROW_W'(colorCode) << {idx, 1'b0});
          state_d = SEL_NEXT;
        end else if (tmo_done) begin
          row_d   = (rowData & ~(ROW_W'(2'b11) << {idx, 1'b0}))
                  | (ROW_W'(RGBY_R) << {idx, 1'b0});
          err_d   = errorMask | (NIB_COUNT'(1) << idx);
          state_d = SEL_NEXT;
        end
      end
      SEL_NEXT: begin
        if (idx == IDX_W'(NIB_COUNT - 1)) begin
          valid_d = 1'b1;
          state_d = SEL_OUTPUT;
        end else begin
          idx_d        = idx + 1'b1;
          sel_d        = SEL_W'(idx_d);
          settle_clear = 1'b1;
          state_d      = SEL_SETTLE;
        end
      end
      SEL_OUTPUT: begin
        if (rowReady) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = SEL_IDLE;
        end
      end
      default: state_d = SEL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= SEL_IDLE;
      idx              <= '0;
      sensorSelect     <= '0;
      sampleReq        <= 1'b0;
      rowData          <= '0;
      errorMask        <= '0;
      rowValid         <= 1'b0;
      selectorComplete <= 1'b0;
    end else begin
      state            <= state_d;
      idx              <= idx_d;
      sensorSelect     <= sel_d;
      sampleReq        <= req_d;
      rowData          <= row_d;
      errorMask        <= err_d;
      rowValid         <= valid_d;
      selectorComplete <= done_d;
    end
  end

  assign busy = (state != SEL_IDLE);

endmodule

// File: tb/tb_nib_selector.sv
// Directed bench for nib_selector: table of full-row scans plus hand-written
// handshake, restart-ignore and mid-scan reset sequences.
module tb_nib_selector;

  localparam int unsigned NC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        startSelector;
  logic [3:0]  sensorSelect;
  logic        sampleReq;
  logic        sampleValid;
  logic [1:0]  colorCode;
  logic [19:0] rowData;
  logic [9:0]  errorMask;
  logic        rowValid;
  logic        rowReady;
  logic        selectorComplete;
  logic        busy;

  always #5 clk = ~clk;

  nib_selector #(
    .NIB_COUNT      (NC),
    .SEL_W          (4),
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .startSelector    (startSelector),
    .sensorSelect     (sensorSelect),
    .sampleReq        (sampleReq),
    .sampleValid      (sampleValid),
    .colorCode        (colorCode),
    .rowData          (rowData),
    .errorMask        (errorMask),
    .rowValid         (rowValid),
    .rowReady         (rowReady),
    .selectorComplete (selectorComplete),
    .busy             (busy)
  );

  typedef struct packed {
    logic [19:0] codes;    // code returned per nib, nib0 in LSBs
    logic [9:0]  never;    // nibs that never answer
    logic [9:0]  late;     // nibs answering on the final timeout cycle
    logic [19:0] exp_row;
    logic [9:0]  exp_err;
    logic [7:0]  exp_lat;
  } vec_t;

  vec_t vecs[4];

  logic [19:0] cfg_codes = '0;
  logic [9:0]  cfg_never = '0;
  logic [9:0]  cfg_late  = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Colour front end: answers one cycle after sampleReq, six cycles later
  // (final timeout cycle) for "late" nibs, or not at all for "never" nibs.
  initial begin
    sampleValid = 1'b0;
    colorCode   = 2'b00;
    forever begin
      @(negedge clk);
      if (sampleReq) begin
        automatic logic [3:0] s = sensorSelect;
        automatic logic [1:0] c = 2'(cfg_codes >> {s, 1'b0});
        if (!cfg_never[s]) begin
          repeat (cfg_late[s] ? 6 : 1) @(posedge clk);
          #1;
          sampleValid = 1'b1;
          colorCode   = c;
          @(posedge clk);
          #1;
          sampleValid = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Starts a scan from the current (post-edge) time; lat is the cycle count
  // until rowValid is seen, or -1 if it never rose.
  task automatic do_scan(output int lat);
    lat = -1;
    startSelector = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk);
      #1;
      startSelector = 1'b0;
      if (rowValid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sel"},   32'(sensorSelect),     32'd0);
    check({tag, "_req"},   32'(sampleReq),        32'd0);
    check({tag, "_row"},   32'(rowData),          32'd0);
    check({tag, "_err"},   32'(errorMask),        32'd0);
    check({tag, "_valid"}, 32'(rowValid),         32'd0);
    check({tag, "_cmpl"},  32'(selectorComplete), 32'd0);
    check({tag, "_busy"},  32'(busy),             32'd0);
  endtask

  initial begin
    int lat;
    int bad;
    int pulses;
    int n_seq;
    int found;
    int busy_cnt;
    logic [3:0] last;
    logic [3:0] seq[16];

    vecs[0] = '{codes: 20'b01_00_11_10_01_00_11_10_01_00, never: 10'h000, late: 10'h000,
                exp_row: 20'b01_00_11_10_01_00_11_10_01_00, exp_err: 10'h000, exp_lat: 8'd61};
    vecs[1] = '{codes: 20'b01_00_11_10_01_00_11_10_01_00, never: 10'h008, late: 10'h000,
                exp_row: 20'b01_00_11_10_01_00_00_10_01_00, exp_err: 10'h008, exp_lat: 8'd66};
    vecs[2] = '{codes: 20'b10_10_10_10_11_10_10_10_10_10, never: 10'h000, late: 10'h020,
                exp_row: 20'b10_10_10_10_11_10_10_10_10_10, exp_err: 10'h000, exp_lat: 8'd66};
    vecs[3] = '{codes: 20'b11_11_11_11_11_11_11_11_11_00, never: 10'h200, late: 10'h000,
                exp_row: 20'b00_11_11_11_11_11_11_11_11_00, exp_err: 10'h200, exp_lat: 8'd66};

    reset         = 1'b0;
    startSelector = 1'b0;
    rowReady      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      cfg_codes = vecs[i].codes;
      cfg_never = vecs[i].never;
      cfg_late  = vecs[i].late;
      rowReady  = 1'b1;
      do_scan(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_row", i), 32'(rowData), 32'(vecs[i].exp_row));
      check($sformatf("v%0d_err", i), 32'(errorMask), 32'(vecs[i].exp_err));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_complete", i), 32'(selectorComplete), 32'd1);
      check($sformatf("v%0d_valid_drop", i), 32'(rowValid), 32'd0);
      check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_row_kept", i), 32'(rowData), 32'(vecs[i].exp_row));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_one_pulse", i), 32'(selectorComplete), 32'd0);
    end

    // rowReady held low for 50 cycles after rowValid
    cfg_codes = vecs[0].codes;
    cfg_never = '0;
    cfg_late  = '0;
    rowReady  = 1'b0;
    do_scan(lat);
    check("stall_latency", 32'(lat), 32'd61);
    bad    = 0;
    pulses = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (!rowValid || rowData !== vecs[0].exp_row || errorMask !== 10'h000) bad++;
      if (selectorComplete) pulses++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    check("stall_no_early_pulse", 32'(pulses), 32'd0);
    rowReady = 1'b1;
    @(posedge clk);
    #1;
    check("stall_complete", 32'(selectorComplete), 32'd1);
    check("stall_valid_drop", 32'(rowValid), 32'd0);
    @(posedge clk);
    #1;
    check("stall_one_pulse", 32'(selectorComplete), 32'd0);

    // second start during SETTLE of nib 4 must be ignored
    last   = 4'hF;
    n_seq  = 0;
    pulses = 0;
    found  = 0;
    for (int k = 0; k < 16; k++) seq[k] = 4'hF;
    startSelector = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk);
      #1;
      startSelector = 1'b0;
      if (sensorSelect != last) begin
        if (n_seq < 16) seq[n_seq] = sensorSelect;
        n_seq++;
        last = sensorSelect;
      end
      if (sensorSelect == 4'd4 && sampleReq == 1'b0 && found == 0) begin
        startSelector = 1'b1;
        found = 1;
      end
      if (selectorComplete) pulses++;
    end
    check("restart_reached_nib4", 32'(found), 32'd1);
    check("restart_seq_len", 32'(n_seq), 32'd10);
    for (int k = 0; k < 10; k++)
      check($sformatf("restart_seq_%0d", k), 32'(seq[k]), 32'(k));
    check("restart_pulses", 32'(pulses), 32'd1);
    check("restart_row", 32'(rowData), 32'(vecs[0].exp_row));
    check("restart_idle", 32'(busy), 32'd0);

    // reset asserted in WAIT of nib 6
    found = 0;
    startSelector = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      startSelector = 1'b0;
      if (sensorSelect == 4'd6 && sampleReq) begin
        found = 1;
        break;
      end
    end
    check("abort_reached_wait6", 32'(found), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_zero("abort");
    reset    = 1'b1;
    pulses   = 0;
    busy_cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (selectorComplete) pulses++;
      if (busy) busy_cnt++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    check("abort_stays_idle", 32'(busy_cnt), 32'd0);
    do_scan(lat);
    check("rescan_latency", 32'(lat), 32'd61);
    check("rescan_row", 32'(rowData), 32'(vecs[0].exp_row));
    check("rescan_err", 32'(errorMask), 32'd0);
    @(posedge clk);
    #1;
    check("rescan_complete", 32'(selectorComplete), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
